// File: rtl/op_enc_pkg.sv
// Shared codes, key-slot indices and the default two-player key map.
package op_enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTING   = 3'd1,
    ST_SYNCING   = 3'd2,
    ST_COUNTDOWN = 3'd3,
    ST_RACING    = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_FINISH    = 3'd6
  } game_state_e;

  typedef enum logic [2:0] {
    OP_NIL      = 3'd0,
    OP_FORWARD  = 3'd1,
    OP_BACKWARD = 3'd2,
    OP_LEFT     = 3'd3,
    OP_RIGHT    = 3'd4
  } op_code_e;

  localparam int unsigned SLOT_FWD   = 0;
  localparam int unsigned SLOT_BACK  = 1;
  localparam int unsigned SLOT_LEFT  = 2;
  localparam int unsigned SLOT_RIGHT = 3;
  localparam int unsigned SLOT_BOOST = 4;
  localparam int unsigned SLOT_HONK  = 5;
  localparam int unsigned N_SLOTS    = 6;
  localparam int unsigned CODE_W     = 9;
  localparam int unsigned MAP_W      = N_SLOTS * CODE_W;

  localparam logic [8:0] P0_FWD   = 9'h01D;
  localparam logic [8:0] P0_BACK  = 9'h01B;
  localparam logic [8:0] P0_LEFT  = 9'h01C;
  localparam logic [8:0] P0_RIGHT = 9'h023;
  localparam logic [8:0] P0_BOOST = 9'h012;
  localparam logic [8:0] P0_HONK  = 9'h029;
  localparam logic [8:0] P1_FWD   = 9'h175;
  localparam logic [8:0] P1_BACK  = 9'h172;
  localparam logic [8:0] P1_LEFT  = 9'h16B;
  localparam logic [8:0] P1_RIGHT = 9'h174;
  localparam logic [8:0] P1_BOOST = 9'h059;
  localparam logic [8:0] P1_HONK  = 9'h070;

  // Per-player slots are packed LSB first: fwd, back, left, right, boost, honk.
  function automatic logic [2*MAP_W-1:0] default_keymap();
    logic [MAP_W-1:0] p0;
    logic [MAP_W-1:0] p1;
    p0 = {P0_HONK, P0_BOOST, P0_RIGHT, P0_LEFT, P0_BACK, P0_FWD};
    p1 = {P1_HONK, P1_BOOST, P1_RIGHT, P1_LEFT, P1_BACK, P1_FWD};
    return {p1, p0};
  endfunction

  localparam logic [2*MAP_W-1:0] DEFAULT_KEYMAP = default_keymap();

  // Direction priority F > B > L > R over a 4-bit direction-slot mask.
  function automatic op_code_e prio_dir(input logic [3:0] m);
    if (m[SLOT_FWD])   return OP_FORWARD;
    if (m[SLOT_BACK])  return OP_BACKWARD;
    if (m[SLOT_LEFT])  return OP_LEFT;
    if (m[SLOT_RIGHT]) return OP_RIGHT;
    return OP_NIL;
  endfunction

endpackage

// File: rtl/op_player_channel.sv
// One cart channel: key snapshot, direction, boost energy/lockout, honk cooldown.
module op_player_channel
  import op_enc_pkg::*;
#(
  parameter logic [MAP_W-1:0] MAP           = DEFAULT_KEYMAP[MAP_W-1:0],
  parameter int unsigned      BOOST_MAX     = 255,
  parameter int unsigned      BOOST_W       = 8,
  parameter int unsigned      BOOST_RESUME  = 64,
  parameter int unsigned      HONK_COOLDOWN = 50_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [511:0]       key_down_i,
  input  logic               key_valid_i,
  input  logic [2:0]         state_i,
  input  logic               tick_i,
  output logic [2:0]         op_code_o,
  output logic               boost_o,
  output logic               honk_o,
  output logic [BOOST_W-1:0] boost_level_o
);

  localparam int unsigned CD_W = (HONK_COOLDOWN > 1) ? $clog2(HONK_COOLDOWN) : 1;
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(HONK_COOLDOWN - 1);
  localparam logic [CD_W-1:0]    CD_ONE  = CD_W'(1);
  localparam logic [BOOST_W-1:0] E_MAX   = BOOST_W'(BOOST_MAX);
  localparam logic [BOOST_W-1:0] E_RES   = BOOST_W'(BOOST_RESUME);
  localparam logic [BOOST_W-1:0] E_ONE   = BOOST_W'(1);

  game_state_e st;
  assign st = game_state_e'(state_i);

  logic [N_SLOTS-1:0] held, new_press;
  logic [N_SLOTS-1:0] snap_q, snap_d;
  op_code_e           dir_q, dir_d;
  op_code_e           op_q, op_d;
  logic [BOOST_W-1:0] energy_q, energy_d;
  logic               lock_q, lock_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               boost_q, boost_d, honk_q, honk_d;
  logic               boost_c, active_held;

  // Look up this player's mapped keys in the held-key vector.
  always_comb begin
    held = '0;
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      held[s] = key_down_i[MAP[s*CODE_W +: CODE_W]];
    end
  end

  // Is the currently active direction key still held?
  always_comb begin
    case (dir_q)
      OP_FORWARD:  active_held = held[SLOT_FWD];
      OP_BACKWARD: active_held = held[SLOT_BACK];
      OP_LEFT:     active_held = held[SLOT_LEFT];
      OP_RIGHT:    active_held = held[SLOT_RIGHT];
      default:     active_held = 1'b0;
    endcase
  end

  // Next-state for direction, energy/lockout, honk cooldown and registered outputs.
  always_comb begin
    snap_d    = snap_q;
    dir_d     = dir_q;
    energy_d  = energy_q;
    lock_d    = lock_q;
    honk_d    = 1'b0;
    cd_d      = (cd_q != '0) ? cd_q - CD_ONE : cd_q;
    new_press = held & ~snap_q;

    if (key_valid_i) begin
      snap_d = held;
      if (|new_press[3:0]) begin
        dir_d = prio_dir(new_press[3:0]);
      end else if (dir_q != OP_NIL && !active_held) begin
        dir_d = prio_dir(held[3:0]);
      end
    end

    // Energy decisions use the pre-update direction even if a strobe lands on a tick.
    boost_c = (st == ST_RACING) && held[SLOT_BOOST] && (dir_q != OP_NIL) &&
              (energy_q != '0) && !lock_q;

    if (st == ST_COUNTDOWN) begin
      energy_d = E_MAX;
      lock_d   = 1'b0;
    end else if (st == ST_RACING && tick_i) begin
      if (boost_c) begin
        energy_d = energy_q - E_ONE;
        if (energy_q == E_ONE) lock_d = 1'b1;
      end else if (energy_q < E_MAX) begin
        energy_d = energy_q + E_ONE;
        if (energy_d >= E_RES) lock_d = 1'b0;
      end
    end

    if (key_valid_i && new_press[SLOT_HONK] && st == ST_RACING && cd_q == '0) begin
      honk_d = 1'b1;
      cd_d   = CD_LOAD;
    end

    op_d    = (st == ST_RACING) ? dir_d : OP_NIL;
    boost_d = boost_c;
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_q   <= '0;
      dir_q    <= OP_NIL;
      op_q     <= OP_NIL;
      energy_q <= E_MAX;
      lock_q   <= 1'b0;
      cd_q     <= '0;
      boost_q  <= 1'b0;
      honk_q   <= 1'b0;
    end else begin
      snap_q   <= snap_d;
      dir_q    <= dir_d;
      op_q     <= op_d;
      energy_q <= energy_d;
      lock_q   <= lock_d;
      cd_q     <= cd_d;
      boost_q  <= boost_d;
      honk_q   <= honk_d;
    end
  end

  assign op_code_o     = op_q;
  assign boost_o       = boost_q;
  assign honk_o        = honk_q;
  assign boost_level_o = energy_q;

endmodule

// File: rtl/multi_player_op_encoder.sv
// Multi-cart operation encoder: shared energy-tick prescaler plus one channel per player.
module multi_player_op_encoder
  import op_enc_pkg::*;
#(
  parameter int unsigned                N_PLAYERS     = 2,
  parameter logic [N_PLAYERS*MAP_W-1:0] KEYMAP        = DEFAULT_KEYMAP,
  parameter int unsigned                TICK_DIV      = 1_000_000,
  parameter int unsigned                BOOST_MAX     = 255,
  parameter int unsigned                BOOST_RESUME  = 64,
  parameter int unsigned                HONK_COOLDOWN = 50_000_000,
  localparam int unsigned               BOOST_W       = $clog2(BOOST_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [511:0]                 key_down,
  input  logic                         key_valid,
  input  logic [2:0]                   state,
  output logic [3*N_PLAYERS-1:0]       op_code,
  output logic [N_PLAYERS-1:0]         boost,
  output logic [N_PLAYERS-1:0]         honk,
  output logic [BOOST_W*N_PLAYERS-1:0] boost_level
);

  localparam int unsigned TD_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TD_W-1:0] TD_LAST = TD_W'(TICK_DIV - 1);
  localparam logic [TD_W-1:0] TD_ONE  = TD_W'(1);

  logic [TD_W-1:0] presc_q, presc_d;
  logic            tick;

  // Prescaler wraps every TICK_DIV clocks; tick marks the last count.
  always_comb begin
    tick    = (presc_q == TD_LAST);
    presc_d = tick ? '0 : presc_q + TD_ONE;
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_ch
    op_player_channel #(
      .MAP          (KEYMAP[p*MAP_W +: MAP_W]),
      .BOOST_MAX    (BOOST_MAX),
      .BOOST_W      (BOOST_W),
      .BOOST_RESUME (BOOST_RESUME),
      .HONK_COOLDOWN(HONK_COOLDOWN)
    ) u_ch (
      .clk_i        (clk),
      .rst_i        (rst),
      .key_down_i   (key_down),
      .key_valid_i  (key_valid),
      .state_i      (state),
      .tick_i       (tick),
      .op_code_o    (op_code[3*p +: 3]),
      .boost_o      (boost[p]),
      .honk_o       (honk[p]),
      .boost_level_o(boost_level[BOOST_W*p +: BOOST_W])
    );
  end

endmodule

// File: tb/tb_multi_player_op_encoder.sv
module tb_multi_player_op_encoder;

  localparam int TDIV = 4;
  localparam int EMAX = 8;
  localparam int ERES = 4;
  localparam int HCD  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_down;
  logic         key_valid;
  logic [2:0]   state;
  logic [5:0]   op_code;
  logic [1:0]   boost, honk;
  logic [7:0]   boost_level;

  bit [5:0] held [2];
  int       codes [2][6];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int       m_presc;
  int       m_dir [2];
  bit [5:0] m_snap [2];
  int       m_energy [2];
  bit       m_lock [2];
  int       m_cd [2];
  int       m_op [2];
  bit       m_boost [2];
  bit       m_honk [2];

  multi_player_op_encoder #(
    .N_PLAYERS    (2),
    .TICK_DIV     (TDIV),
    .BOOST_MAX    (EMAX),
    .BOOST_RESUME (ERES),
    .HONK_COOLDOWN(HCD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_down   (key_down),
    .key_valid  (key_valid),
    .state      (state),
    .op_code    (op_code),
    .boost      (boost),
    .honk       (honk),
    .boost_level(boost_level)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_down = '0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 6; s++)
        if (held[p][s]) key_down[codes[p][s]] = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Direction code of the highest-priority set bit (F,B,L,R -> 1..4), 0 if none.
  function automatic int top_dir(input bit [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_presc = 0;
    for (int p = 0; p < 2; p++) begin
      m_dir[p] = 0; m_snap[p] = '0; m_energy[p] = EMAX; m_lock[p] = 0;
      m_cd[p] = 0; m_op[p] = 0; m_boost[p] = 0; m_honk[p] = 0;
    end
  endtask

  // One clock edge of the behavioural model, using inputs as sampled at the edge.
  task automatic model_step();
    bit tick, racing, bc, hk;
    bit [5:0] nw;
    if (rst) begin model_reset(); return; end
    tick    = (m_presc == TDIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    racing  = (state == 3'd4);
    for (int p = 0; p < 2; p++) begin
      bc = racing && held[p][4] && m_dir[p] != 0 && m_energy[p] > 0 && !m_lock[p];
      nw = held[p] & ~m_snap[p];
      hk = 0;
      if (key_valid) begin
        if (nw[3:0] != 0) m_dir[p] = top_dir(nw[3:0]);
        else if (m_dir[p] != 0 && !held[p][m_dir[p]-1]) m_dir[p] = top_dir(held[p][3:0]);
        m_snap[p] = held[p];
        hk = nw[5] && racing && m_cd[p] == 0;
      end
      if (hk) m_cd[p] = HCD - 1;
      else if (m_cd[p] > 0) m_cd[p]--;
      if (state == 3'd3) begin
        m_energy[p] = EMAX; m_lock[p] = 0;
      end else if (racing && tick) begin
        if (bc) begin
          m_energy[p]--;
          if (m_energy[p] == 0) m_lock[p] = 1;
        end else if (m_energy[p] < EMAX) begin
          m_energy[p]++;
          if (m_energy[p] >= ERES) m_lock[p] = 0;
        end
      end
      m_op[p]    = racing ? m_dir[p] : 0;
      m_boost[p] = bc;
      m_honk[p]  = hk;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("op%0d", p),    op_code[3*p +: 3],     m_op[p]);
      chk($sformatf("boost%0d", p), boost[p],              m_boost[p]);
      chk($sformatf("honk%0d", p),  honk[p],               m_honk[p]);
      chk($sformatf("level%0d", p), boost_level[4*p +: 4], m_energy[p]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic strobe();
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic wait_energy(input int p, input int val, input int budget);
    int n = 0;
    while (m_energy[p] != val && n < budget) begin step(); n++; end
    if (m_energy[p] != val) begin
      n_tests++; n_fail++;
      $display("FAIL wait_energy%0d: budget %0d expired waiting for %0d", p, budget, val);
    end
  endtask

  typedef struct {
    bit       kv;
    bit [2:0] st;
    bit [5:0] h0;
    int       exp_op0;
  } vec_t;

  vec_t vecs [11];

  initial begin
    codes = '{'{'h01D, 'h01B, 'h01C, 'h023, 'h012, 'h029},
              '{'h175, 'h172, 'h16B, 'h174, 'h059, 'h070}};
    vecs = '{
      '{1, 3'd4, 6'b000001, 1},  // W down
      '{0, 3'd4, 6'b000001, 1},
      '{1, 3'd4, 6'b000101, 3},  // A down: most recent wins
      '{1, 3'd4, 6'b000001, 1},  // A up, W held
      '{1, 3'd4, 6'b000000, 0},  // W up
      '{1, 3'd4, 6'b001010, 2},  // S+D new together
      '{1, 3'd4, 6'b000000, 0},
      '{1, 3'd5, 6'b001010, 0},  // same in PAUSE
      '{0, 3'd5, 6'b001010, 0},
      '{0, 3'd4, 6'b001010, 2},  // back to RACING, no strobe
      '{1, 3'd4, 6'b001000, 4}   // S up, D still held
    };
    held[0] = '0; held[1] = '0;
    key_valid = 1'b0;
    state = 3'd4;
    rst = 1'b1;
    model_reset();
    #3;
    chk("rst_op",    op_code,     6'd0);
    chk("rst_boost", boost,       2'd0);
    chk("rst_honk",  honk,        2'd0);
    chk("rst_level", boost_level, 8'h88);
    step(); step();
    rst = 1'b0;
    step();

    // Direction table
    for (int i = 0; i < 11; i++) begin
      key_valid = vecs[i].kv;
      state     = vecs[i].st;
      held[0]   = vecs[i].h0;
      step();
      key_valid = 1'b0;
      chk($sformatf("vec%0d_op0", i), op_code[2:0], vecs[i].exp_op0);
    end

    // Boost drain and lockout
    held[0] = '0; strobe();
    state = 3'd3; step(); state = 3'd4;
    held[0] = 6'b010001; strobe();
    wait_energy(0, 0, 60);
    chk("drain_level0", boost_level[3:0], 0);
    step(); step();
    chk("drain_boost0", boost[0], 0);
    held[0] = 6'b000001; strobe();
    wait_energy(0, 3, 40);
    held[0] = 6'b010001; strobe();
    step();
    chk("lock_at3_boost0", boost[0], 0);
    wait_energy(0, 4, 10);
    step();
    chk("resume_at4_boost0", boost[0], 1);

    // Boost needs a direction
    held[0] = 6'b010000; strobe();
    for (int i = 0; i < 6; i++) step();
    chk("nodir_boost0", boost[0], 0);
    state = 3'd3; step(); state = 3'd4;
    chk("countdown_level0", boost_level[3:0], EMAX);

    // Honk rate limit
    held[0] = '0; held[1] = '0; strobe();
    for (int c = 0; c < 20; c++) begin
      case (c)
        0:  begin held[0][5] = 1; key_valid = 1; end
        2:  begin held[0][5] = 0; key_valid = 1; end
        10: begin held[0][5] = 1; held[1][5] = 1; key_valid = 1; end
        12: begin held[0][5] = 0; held[1][5] = 0; key_valid = 1; end
        17: begin held[0][5] = 1; key_valid = 1; end
        default: key_valid = 0;
      endcase
      step();
      key_valid = 0;
      case (c)
        0:  chk("honk_first", honk[0], 1);
        1:  chk("honk_single", honk[0], 0);
        10: begin chk("honk_cooldown", honk[0], 0); chk("honk_p1", honk[1], 1); end
        11: chk("honk_p1_single", honk[1], 0);
        17: chk("honk_after_cd", honk[0], 1);
        default: ;
      endcase
    end

    // Async reset mid-race
    held[0] = '0; strobe();
    state = 3'd3; step(); state = 3'd4;
    held[0] = 6'b010001; strobe();
    wait_energy(0, 5, 40);
    #2;
    held[0] = 6'b000001;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_op",    op_code,     6'd0);
    chk("arst_boost", boost,       2'd0);
    chk("arst_level", boost_level, 8'h88);
    step(); step();
    rst = 1'b0;
    step();
    strobe();
    chk("post_rst_op0", op_code[2:0], 1);

    // Randomized against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        held[0] = 6'($urandom);
        held[1] = 6'($urandom);
        key_valid = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          7:       state = 3'd5;
          8:       state = 3'd3;
          9:       state = 3'd0;
          default: state = 3'd4;
        endcase
      end
      step();
      key_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multi_player_op_encoder.md
# multi_player_op_encoder

Parametrised successor to the two-cart keyboard operation encoder. It serves `N_PLAYERS` carts, each with its own key map. Direction is resolved most-recent-wins, boost is drawn from a per-cart energy meter with lockout hysteresis, and honk is a rate-limited one-cycle pulse. It sits between the PS/2 `KeyboardDecoder` (instantiated by the parent) and the cart physics/sound blocks, and is gated by the game FSM state.

## Interface
Parameters:
- `N_PLAYERS`, 2: number of cart channels (1–4).
- `KEYMAP`, default 2-player map: `N_PLAYERS*54` bits, 6×9-bit codes per player, LSB first `{fwd, back, left, right, boost, honk}`. The default map is P0 = 01D, 01B, 01C, 023, 012, 029 and P1 = 175, 172, 16B, 174, 059, 070.
- `TICK_DIV`, 1_000_000: clk cycles per energy tick.
- `BOOST_MAX`, 255: full energy value; `BOOST_W = $clog2(BOOST_MAX+1)`.
- `BOOST_RESUME`, 64: energy needed to leave lockout.
- `HONK_COOLDOWN`, 50_000_000: cycles during which honk presses are ignored.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_down`  in  512  held-key vector from the decoder.
- `key_valid`  in  1  one-cycle strobe; `key_down` has changed.
- `state`  in  3  FSM state (IDLE 0 … RACING 4, PAUSE 5, FINISH 6).
- `op_code`  out  `3*N_PLAYERS`  per-player direction (NIL 0, FORWARD 1, BACKWARD 2, LEFT 3, RIGHT 4).
- `boost`  out  `N_PLAYERS`  per-player boost active.
- `honk`  out  `N_PLAYERS`  per-player one-cycle honk pulse.
- `boost_level`  out  `BOOST_W*N_PLAYERS`  per-player energy, for the HUD.

## Operation
- All outputs are registered. Reset values: `op_code` NIL, `boost` 0, `honk` 0, `boost_level` `BOOST_MAX`, lockout 0, cooldown 0, held snapshot 0, tick prescaler 0.
- **Held snapshot.** Each player has a 6-bit snapshot. It updates only on `key_valid`. A new press is a bit that is 1 in the current `key_down` and 0 in the snapshot.
- **Direction register.** Each player has a 3-bit direction register, updated on `key_valid`:
  - A new direction press becomes active. If several are new at once, priority is F>B>L>R.
  - If the active key is released with no new press, the direction falls back to the highest-priority key still held, else NIL.
  - Other events keep the current direction.
- **Direction output.** `op_code` = direction register when `state==RACING`, else NIL. The register keeps tracking in every state.
- **Opposing keys.** F+B both held with no new press: the active key stays. No cancellation.
- **Energy tick.** A shared prescaler produces a one-cycle tick every `TICK_DIV` clocks.
- **Boost condition.** `boost` = RACING ∧ boost key held ∧ direction≠NIL ∧ energy>0 ∧ ¬lockout.
- **Energy update (on tick, RACING only).**
  - Boost active: energy−1. When energy reaches 0, set lockout.
  - Else, if energy<`BOOST_MAX`: energy+1. Clear lockout when energy ≥ `BOOST_RESUME`.
  - Energy saturates at 0 and at `BOOST_MAX`.
- **Energy in other states.** Energy is frozen in PAUSE/FINISH/IDLE/SETTING/SYNCING. On every cycle with `state==COUNTDOWN`, energy is set to `BOOST_MAX` and lockout is cleared.
- **Honk.** On `key_valid` with a new honk press, `state==RACING`, and cooldown==0: pulse `honk` for 1 cycle and load cooldown with `HONK_COOLDOWN−1`.
  - Cooldown decrements every cycle in every state.
  - Presses during cooldown are dropped, not queued.
- **Channel independence.** Players are fully independent. Identical codes in two players' maps drive both players.

## Timing
- `op_code`, `honk`: 1 cycle after the `key_valid` cycle.
- `boost`: 1 cycle after its condition changes (key held, direction, lockout, state).
- `boost_level`: 1 cycle after the tick.
- State leaving RACING: `op_code`/`boost` go to NIL/0 the next cycle. A honk pulse already issued still completes its single cycle.
- Tick and `key_valid` in the same cycle: the direction update and the energy update both apply. The energy uses the pre-update boost condition.
- Asynchronous `rst` mid-race: all registers return to reset values immediately. After release, the first `key_valid` treats every held key as a new press.

## Structure
- The shared package `op_enc_pkg` holds:
  - state codes, op codes;
  - key-slot indices (`SLOT_FWD`…`SLOT_HONK`);
  - default key-code constants and the default `KEYMAP` builder.
- Sub-module `op_player_channel`, generated `N_PLAYERS` times. It contains:
  - snapshot, direction register;
  - energy/lockout;
  - honk cooldown.
- The top level holds only the tick prescaler and the keymap slicing.

## Test plan
Bench parameters: `TICK_DIV=4`, `BOOST_MAX=8`, `BOOST_RESUME=4`, `HONK_COOLDOWN=16`, `N_PLAYERS=2`, state=RACING.
- **Most-recent-wins.** Sequence: W down → op_code[0]=1. A down → 3. A up while W held → 1. W up → 0. Each change lands 1 cycle after `key_valid`.
- **Simultaneous new presses.** S+D new in one strobe → 2. Repeat with state=PAUSE → op_code stays 0 while tracking continues. Switch back to RACING → 2 with no new strobe.
- **Boost drain and lockout.** W+LSHIFT held. After 8 ticks, energy=0, boost=0, lockout set. Release LSHIFT: `boost_level` climbs 1 per tick. Re-press at energy 3 → boost 0. Energy 4 → boost 1.
- **Boost needs a direction.** LSHIFT alone held → boost 0 and energy recharges. State=COUNTDOWN for 1 cycle → `boost_level`=8.
- **Honk rate limit.** SPACE press → honk[0] pulse of 1 cycle. Re-press at cycle +10 → no pulse. Re-press at +17 → pulse. Player 1 NUM0 at +10 → honk[1] pulses independently.
- **Async reset mid-race.** Assert `rst` with W held and energy 5 → all outputs reset asynchronously, `boost_level`=8. The first `key_valid` after release, with W still held → op_code[0]=1.
